// File: rtl/anubis_pkg.sv
// Shared types and constants for the Anubis round sequencer slice.
package anubis_pkg;

    localparam int ANUBIS_BLK_W          = 128;
    localparam int ANUBIS_ROUNDS_DEFAULT = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_RESP
    } seq_state_t;

endpackage

// File: rtl/anubis_round_sequencer_if.sv
// Requester, datapath and response signals of the round sequencer; slave = sequencer side.
interface anubis_round_sequencer_if #(
    parameter int NREQ = 2
);
    import anubis_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_is_key;
    logic [NREQ*ANUBIS_BLK_W-1:0] req_data;
    logic [NREQ-1:0]              req_ready;

    logic [ANUBIS_BLK_W-1:0]      dp_data;
    logic                         dp_load_key;
    logic                         dp_load_data;
    logic                         dp_round_en;
    logic [3:0]                   dp_round_idx;
    logic                         dp_final;
    logic [ANUBIS_BLK_W-1:0]      dp_result;

    logic                         rsp_valid;
    logic [IDW-1:0]               rsp_id;
    logic [ANUBIS_BLK_W-1:0]      rsp_data;
    logic                         rsp_ready;

    modport slave (
        input  req_valid, req_is_key, req_data, dp_result, rsp_ready,
        output req_ready, dp_data, dp_load_key, dp_load_data, dp_round_en,
               dp_round_idx, dp_final, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_is_key, req_data, dp_result, rsp_ready,
        input  req_ready, dp_data, dp_load_key, dp_load_data, dp_round_en,
               dp_round_idx, dp_final, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/anubis_rr_arbiter.sv
// Request arbiter: round-robin by default, fixed lowest-index priority when
// ANUBIS_SEQ_FIXED_PRIO_EN is defined (no pointer state in that build).
module anubis_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic                     accept,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     any_req
);
    localparam int IDW = $clog2(NREQ);

    int search_base;

`ifdef ANUBIS_SEQ_FIXED_PRIO_EN
    always_comb begin
        search_base = 0;
    end
`else
    logic [IDW-1:0] rr_ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (accept) begin
            rr_ptr_reg <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        search_base = int'(rr_ptr_reg);
    end
`endif

    // Walk the search order backwards so the last hit is the highest priority.
    always_comb begin
        gnt_id  = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[IDW'((search_base + k) % NREQ)]) begin
                gnt_id  = IDW'((search_base + k) % NREQ);
                any_req = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = any_req && (gnt_id == IDW'(gi));
    end

endmodule

// File: rtl/anubis_round_sequencer.sv
// Shares one iterative Anubis round datapath among NREQ requesters: load, ROUNDS rounds,
// final transform, tagged response. Arbitration mode selected by ANUBIS_SEQ_FIXED_PRIO_EN.
module anubis_round_sequencer
    import anubis_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ROUNDS = ANUBIS_ROUNDS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    anubis_round_sequencer_if.slave   bus
);
    localparam int         IDW        = $clog2(NREQ);
    localparam logic [3:0] ROUND_LAST = 4'(ROUNDS - 1);

    seq_state_t              state_reg, state_next;
    logic                    key_loaded_reg;
    logic                    is_key_reg;
    logic [IDW-1:0]          id_reg;
    logic [ANUBIS_BLK_W-1:0] operand_reg;
    logic [3:0]              round_cnt_reg;
    logic [ANUBIS_BLK_W-1:0] rsp_data_reg;

    logic [NREQ-1:0]         grant;
    logic [IDW-1:0]          gnt_id;
    logic                    any_req;
    logic                    accept;

    anubis_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .accept  (accept),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .any_req (any_req)
    );

    assign accept        = (state_reg == ST_IDLE) && any_req && !reset;
    assign bus.req_ready = accept ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            key_loaded_reg <= 1'b0;
            is_key_reg     <= 1'b0;
            id_reg         <= '0;
            operand_reg    <= '0;
            round_cnt_reg  <= '0;
            rsp_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        id_reg      <= gnt_id;
                        is_key_reg  <= bus.req_is_key[gnt_id];
                        operand_reg <= bus.req_data[gnt_id*ANUBIS_BLK_W +: ANUBIS_BLK_W];
                    end
                end
                ST_LOAD: begin
                    round_cnt_reg <= '0;
                    if (is_key_reg) begin
                        key_loaded_reg <= 1'b1;
                    end else if (!key_loaded_reg) begin
                        rsp_data_reg <= '0;
                    end
                end
                ST_ROUND: begin
                    if (round_cnt_reg != ROUND_LAST) begin
                        round_cnt_reg <= round_cnt_reg + 4'd1;
                    end
                end
                ST_FINAL: rsp_data_reg <= bus.dp_result;
                default: ;
            endcase
        end
    end

    // A keyless encrypt still answers through RESP so the zero result obeys rsp_ready.
    always_comb begin
        state_next       = state_reg;
        bus.dp_data      = '0;
        bus.dp_load_key  = 1'b0;
        bus.dp_load_data = 1'b0;
        bus.dp_round_en  = 1'b0;
        bus.dp_round_idx = '0;
        bus.dp_final     = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_id       = '0;
        bus.rsp_data     = '0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (is_key_reg) begin
                    bus.dp_data     = operand_reg;
                    bus.dp_load_key = 1'b1;
                    state_next      = ST_IDLE;
                end else if (key_loaded_reg) begin
                    bus.dp_data      = operand_reg;
                    bus.dp_load_data = 1'b1;
                    state_next       = ST_ROUND;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_ROUND: begin
                bus.dp_round_en  = 1'b1;
                bus.dp_round_idx = round_cnt_reg;
                if (round_cnt_reg == ROUND_LAST) state_next = ST_FINAL;
            end
            ST_FINAL: begin
                bus.dp_final = 1'b1;
                state_next   = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = id_reg;
                bus.rsp_data  = rsp_data_reg;
                if (bus.rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_anubis_round_sequencer.sv
// Directed bench for anubis_round_sequencer with a toy round datapath and a response scoreboard.
module tb_anubis_round_sequencer;
    import anubis_pkg::*;

    localparam int NREQ   = 2;
    localparam int ROUNDS = 12;
    localparam int IDW    = $clog2(NREQ);

    localparam logic [127:0] K  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P1 = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] P2 = 128'h55aa55aa00ff00ff1234567812345678;
    localparam logic [127:0] P3 = 128'h8000000000000000000000000000000f;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    anubis_round_sequencer_if #(.NREQ(NREQ)) bus ();

    anubis_round_sequencer #(.NREQ(NREQ), .ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] k,
                                         input logic [3:0] i);
        return {s[126:0], s[127]} ^ k ^ {124'd0, i};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p);
        logic [127:0] s;
        s = p;
        for (int i = 0; i < ROUNDS; i++) s = rnd(s, k, 4'(i));
        return s ^ ~k;
    endfunction

    // Toy datapath: result shows the final (no-mix) transform of the current state.
    logic [127:0] dp_key = '0;
    logic [127:0] dp_state = '0;
    always @(posedge clk) begin
        if (bus.dp_load_key)  dp_key   <= bus.dp_data;
        if (bus.dp_load_data) dp_state <= bus.dp_data;
        if (bus.dp_round_en)  dp_state <= rnd(dp_state, dp_key, bus.dp_round_idx);
    end
    assign bus.dp_result = dp_state ^ ~dp_key;

    int n_key = 0, n_ld = 0, n_rnd = 0, n_fin = 0, idx_err = 0, excl_err = 0;
    logic [3:0] exp_idx = '0;
    always @(negedge clk) begin
        if (bus.dp_load_key)  n_key <= n_key + 1;
        if (bus.dp_final)     n_fin <= n_fin + 1;
        if (bus.dp_load_data) begin
            n_ld    <= n_ld + 1;
            exp_idx <= '0;
        end
        if (bus.dp_round_en) begin
            n_rnd   <= n_rnd + 1;
            exp_idx <= exp_idx + 4'd1;
            if (bus.dp_round_idx !== exp_idx) idx_err <= idx_err + 1;
        end
        if (int'(bus.dp_load_key) + int'(bus.dp_load_data) + int'(bus.dp_round_en)
            + int'(bus.dp_final) > 1) excl_err <= excl_err + 1;
    end

    typedef struct {
        logic [IDW-1:0] id;
        logic [127:0]   data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    int rr_exp = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] ctl_vec();
        return 128'({bus.req_ready, bus.dp_load_key, bus.dp_load_data, bus.dp_round_en,
                     bus.dp_round_idx, bus.dp_final, bus.rsp_valid, bus.rsp_id});
    endfunction

    task automatic send(input int id, input logic is_key, input logic [127:0] data);
        int t;
        t = 0;
        bus.req_valid[id]            = 1'b1;
        bus.req_is_key[id]           = is_key;
        bus.req_data[id*128 +: 128]  = data;
        #1;
        while (!bus.req_ready[id] && t < 50) begin
            wait_cycle();
            t++;
        end
        chk($sformatf("ready_req%0d", id), 128'(bus.req_ready), 128'(1) << id);
        wait_cycle();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!bus.rsp_valid && n < 60) begin
            wait_cycle();
            n++;
        end
    endtask

    task automatic take_rsp(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 128'(bus.rsp_valid), 128'(1));
        chk({tag, "_sb_depth"}, 128'(sb_q.size()), 128'(1));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_id"}, 128'(bus.rsp_id), 128'(e.id));
            chk({tag, "_data"}, bus.rsp_data, e.data);
        end
        wait_cycle();
    endtask

    initial begin
        int n, nr, nl, t;
        logic [127:0] held;

        bus.req_valid  = '0;
        bus.req_is_key = '0;
        bus.req_data   = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) wait_cycle();
        chk("reset_ctl", ctl_vec(), '0);
        chk("reset_dp_data", bus.dp_data, '0);
        chk("reset_rsp_data", bus.rsp_data, '0);
        reset = 1'b0;
        wait_cycle();

        // Key load then encrypt from requester 0.
        send(0, 1'b1, K);
        chk("key_strobe", 128'({bus.dp_load_key, bus.dp_load_data, bus.dp_round_en, bus.dp_final}),
            128'(4'b1000));
        chk("key_dp_data", bus.dp_data, K);
        wait_cycle();
        send(0, 1'b0, P0);
        sb_q.push_back('{id: IDW'(0), data: model(K, P0)});
        wait_rsp(n);
        chk("enc_latency", 128'(n), 128'(ROUNDS + 3));
        chk("enc_n_key", 128'(n_key), 128'(1));
        chk("enc_n_load", 128'(n_ld), 128'(1));
        chk("enc_n_round", 128'(n_rnd), 128'(ROUNDS));
        chk("enc_n_final", 128'(n_fin), 128'(1));
        take_rsp("enc");
        rr_exp = 1;

        // Contention: both requesters encrypt continuously.
        bus.req_is_key          = '0;
        bus.req_data[0 +: 128]  = P0;
        bus.req_data[128 +: 128] = P1;
        bus.req_valid           = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            int g;
            t = 0;
            while (bus.req_ready == '0 && t < 50) begin
                wait_cycle();
                t++;
            end
`ifdef ANUBIS_SEQ_FIXED_PRIO_EN
            g = 0;
`else
            g = rr_exp;
            rr_exp = 1 - rr_exp;
`endif
            chk($sformatf("cont_grant%0d", i), 128'(bus.req_ready), 128'(1) << g);
            sb_q.push_back('{id: IDW'(g), data: model(K, (g == 1) ? P1 : P0)});
            wait_cycle();
            wait_rsp(n);
            take_rsp($sformatf("cont%0d", i));
        end
        bus.req_valid = '0;

        // Back-pressure with a withdrawn request from requester 1 during the stall.
        bus.rsp_ready = 1'b0;
        send(0, 1'b0, P2);
        sb_q.push_back('{id: IDW'(0), data: model(K, P2)});
        wait_rsp(n);
        held = bus.rsp_data;
        for (int i = 0; i < 5; i++) begin
            wait_cycle();
            if (i == 0) bus.req_valid[1] = 1'b1;
            if (i == 1) bus.req_valid[1] = 1'b0;
            #1;
            chk($sformatf("bp_valid%0d", i), 128'(bus.rsp_valid), 128'(1));
            chk($sformatf("bp_data%0d", i), bus.rsp_data, held);
            chk($sformatf("bp_ready%0d", i), 128'(bus.req_ready), '0);
        end
        bus.rsp_ready = 1'b1;
        take_rsp("bp");
        chk("bp_single", 128'(bus.rsp_valid), '0);
        rr_exp = 1;

        // The withdrawn request must not have moved the round-robin pointer.
        bus.req_valid = 2'b11;
        #1;
`ifdef ANUBIS_SEQ_FIXED_PRIO_EN
        rr_exp = 0;
`endif
        chk("wd_grant", 128'(bus.req_ready), 128'(1) << rr_exp);
        sb_q.push_back('{id: IDW'(rr_exp), data: model(K, (rr_exp == 1) ? P1 : P0)});
        wait_cycle();
        bus.req_valid = '0;
        wait_rsp(n);
        take_rsp("wd");

        // Reset in the middle of the rounds aborts silently and forgets the key.
        send(0, 1'b0, P3);
        t = 0;
        while (!(bus.dp_round_en && bus.dp_round_idx == 4'd5) && t < 40) begin
            wait_cycle();
            t++;
        end
        chk("mid_idx", 128'(bus.dp_round_idx), 128'(5));
        reset = 1'b1;
        wait_cycle();
        reset = 1'b0;
        #1;
        chk("rst_ctl", ctl_vec(), '0);
        chk("rst_dp_data", bus.dp_data, '0);
        chk("rst_rsp_data", bus.rsp_data, '0);
        nr = n_rnd;
        nl = n_ld;
        repeat (20) wait_cycle();
        chk("rst_no_rsp", 128'(bus.rsp_valid), '0);
        chk("rst_no_rounds", 128'(n_rnd - nr), '0);

        // Encrypt with no key loaded answers zero without touching the datapath.
        send(0, 1'b0, P0);
        sb_q.push_back('{id: IDW'(0), data: '0});
        wait_rsp(n);
        chk("nokey_rounds", 128'(n_rnd - nr), '0);
        chk("nokey_loads", 128'(n_ld - nl), '0);
        take_rsp("nokey");

        chk("idx_sequence", 128'(idx_err), '0);
        chk("strobe_exclusive", 128'(excl_err), '0);
        chk("sb_empty", 128'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
